// File: rtl/register_file_pkg.sv
// ============================================================================
//  Module   : register_file_pkg
//  Brief    : Shared constants and state encoding for the index serializer.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package register_file_pkg;

    localparam int N      = 32;
    localparam int LOG2_N = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lsb_encoder_32_x_5.sv
// ============================================================================
//  Module   : lsb_encoder_32_x_5
//  Brief    : Lowest-set-bit index of a mask plus a "exactly one bit set" flag.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lsb_encoder_32_x_5 #(
    parameter int N      = register_file_pkg::N,
    parameter int LOG2_N = register_file_pkg::LOG2_N
) (
    input  logic [N-1:0]      mask,
    output logic [LOG2_N-1:0] index,
    output logic              single
);

    localparam logic [N-1:0] c_one = N'(1);

    // Scan from the top so the lowest set bit is the final assignment.
    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = LOG2_N'(i);
            end
        end
    end

    assign single = (mask != '0) && ((mask & (mask - c_one)) == '0);

endmodule

`default_nettype wire

// File: rtl/encoder_32_x_5_serializer.sv
// ============================================================================
//  Module   : encoder_32_x_5_serializer
//  Brief    : Accepts a select vector and emits the index of every set bit in
//             ascending order over a valid/ready handshake. Define
//             STRICT_ONEHOT_EN to reject multi-hot vectors with an err pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module encoder_32_x_5_serializer #(
    parameter int N      = register_file_pkg::N,
    parameter int LOG2_N = register_file_pkg::LOG2_N
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOG2_N-1:0] out_index,
    output logic              out_last,
    output logic              err
);

    import register_file_pkg::*;

    localparam logic [N-1:0] c_one = N'(1);

    state_t              r_state;
    state_t              w_next_state;
    logic [N-1:0]        r_pending;
    logic [N-1:0]        w_next_pending;
    logic [LOG2_N-1:0]   w_low_idx;
    logic                w_low_single;

    lsb_encoder_32_x_5 #(
        .N      (N),
        .LOG2_N (LOG2_N)
    ) u_lsb_encoder (
        .mask   (r_pending),
        .index  (w_low_idx),
        .single (w_low_single)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == BUSY);
    assign out_index = (r_state == BUSY) ? w_low_idx : '0;
    assign out_last  = (r_state == BUSY) && w_low_single;

`ifdef STRICT_ONEHOT_EN
    logic w_in_multi;
    logic w_next_err;
    logic r_err;

    assign w_in_multi = (in_vec & (in_vec - c_one)) != '0;
    assign err        = r_err;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        w_next_state   = r_state;
        w_next_pending = r_pending;
`ifdef STRICT_ONEHOT_EN
        w_next_err     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid) begin
`ifdef STRICT_ONEHOT_EN
                    if (w_in_multi) begin
                        w_next_pending = '0;
                        w_next_err     = 1'b1;
                    end else begin
                        w_next_pending = in_vec;
                        if (in_vec != '0) begin
                            w_next_state = BUSY;
                        end
                    end
`else
                    w_next_pending = in_vec;
                    if (in_vec != '0) begin
                        w_next_state = BUSY;
                    end
`endif
                end
            end
            BUSY: begin
                if (out_ready) begin
                    // Clearing the lowest set bit retires exactly the emitted index.
                    w_next_pending = r_pending & (r_pending - c_one);
                    if (w_low_single) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state   = IDLE;
                w_next_pending = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_next_pending;
        end
    end

`ifdef STRICT_ONEHOT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_next_err;
        end
    end
`endif

endmodule

`default_nettype wire
